// File: rtl/ack_bus_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// ack_bus_pkg
// Shared definitions for the acknowledge bus arbiter:
//   - default source count and bus hold length
//   - FSM state encoding
//   - id_width(): width of a source ID, never narrower than one bit
// ---------------------------------------------------------------------------
package ack_bus_pkg;

  localparam int DEFAULT_N_SRC       = 4;
  localparam int DEFAULT_HOLD_CYCLES = 1;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_DRIVE = 1'b1
  } arb_state_e;

  // max(1, clog2(n)) so a two-source arbiter still gets a one-bit ID
  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ack_bus_arbiter_if.sv
// ---------------------------------------------------------------------------
// ack_bus_arbiter_if
// Bundles the request side and the acknowledge bus of the arbiter.
//   req_i             : per-source request levels (rising edge = one request)
//   ovr_clr_i         : clears all sticky overrun flags
//   ack_ready_o       : per-source "no request pending"
//   winner_id_o       : ID of the most recent grant
//   ack_event_o       : one-cycle pulse on the first bus cycle of a grant
//   ack_valid_n_bus_o : active-low bus valid
//   ack_id_bus_o      : granted ID while the bus is valid, else 0
//   overrun_o         : sticky per-source lost-request flags
// Modports: master = request sources, slave = arbiter.
// ---------------------------------------------------------------------------
interface ack_bus_arbiter_if
  import ack_bus_pkg::*;
#(
  parameter int N_SRC = DEFAULT_N_SRC
);

  localparam int ID_W = id_width(N_SRC);

  logic [N_SRC-1:0] req_i;
  logic             ovr_clr_i;
  logic [N_SRC-1:0] ack_ready_o;
  logic [ID_W-1:0]  winner_id_o;
  logic             ack_event_o;
  logic             ack_valid_n_bus_o;
  logic [ID_W-1:0]  ack_id_bus_o;
  logic [N_SRC-1:0] overrun_o;

  modport master (
    output req_i, ovr_clr_i,
    input  ack_ready_o, winner_id_o, ack_event_o,
           ack_valid_n_bus_o, ack_id_bus_o, overrun_o
  );

  modport slave (
    input  req_i, ovr_clr_i,
    output ack_ready_o, winner_id_o, ack_event_o,
           ack_valid_n_bus_o, ack_id_bus_o, overrun_o
  );

endinterface

// File: rtl/ack_bus_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational round-robin selector: returns the first set bit of
// 'pending' at or above 'rr_ptr', scanning upward and wrapping at N_SRC.
//   pending : request vector
//   rr_ptr  : scan start position
//   sel     : selected source ID (0 when nothing pending)
//   any     : at least one pending bit
// ---------------------------------------------------------------------------
module rr_pick
  import ack_bus_pkg::*;
#(
  parameter  int N_SRC = DEFAULT_N_SRC,
  localparam int ID_W  = id_width(N_SRC)
) (
  input  logic [N_SRC-1:0] pending,
  input  logic [ID_W-1:0]  rr_ptr,
  output logic [ID_W-1:0]  sel,
  output logic             any
);

  // One spare bit so rr_ptr + offset cannot overflow before the wrap
  localparam int SUM_W = ID_W + 1;

  logic [SUM_W-1:0] idx;

  // The first hit in scan order wins; later hits are ignored via 'any'
  always_comb begin
    sel = '0;
    any = 1'b0;
    idx = '0;
    for (int k = 0; k < N_SRC; k++) begin
      idx = {1'b0, rr_ptr} + SUM_W'(k);
      if (idx >= SUM_W'(N_SRC)) begin
        idx = idx - SUM_W'(N_SRC);
      end
      if (!any && pending[idx[ID_W-1:0]]) begin
        any = 1'b1;
        sel = idx[ID_W-1:0];
      end
    end
  end

endmodule

// File: rtl/ack_bus_arbiter.sv
// ---------------------------------------------------------------------------
// ack_bus_arbiter
// Turns rising edges on per-source request lines into grants on a shared
// active-low acknowledge bus. Each grant drives the bus for HOLD_CYCLES
// cycles followed by at least one idle turnaround cycle. Sources are served
// round-robin. A second request edge from a source that is still waiting is
// dropped and recorded in a sticky overrun flag.
//   clk   : clock, all state changes on the rising edge
//   rst_n : synchronous active-low reset
//   bus   : ack_bus_arbiter_if slave modport (requests in, bus out)
// ---------------------------------------------------------------------------
module ack_bus_arbiter
  import ack_bus_pkg::*;
#(
  parameter int N_SRC       = DEFAULT_N_SRC,
  parameter int HOLD_CYCLES = DEFAULT_HOLD_CYCLES
) (
  input logic              clk,
  input logic              rst_n,
  ack_bus_arbiter_if.slave bus
);

  localparam int ID_W = id_width(N_SRC);

  arb_state_e       state;
  logic [N_SRC-1:0] req_q;
  logic [N_SRC-1:0] pending;
  logic [N_SRC-1:0] overrun;
  logic [ID_W-1:0]  rr_ptr;
  logic [3:0]       hold_cnt;
  logic [ID_W-1:0]  winner_id;
  logic [ID_W-1:0]  ack_id_bus;
  logic             ack_event;
  logic             ack_valid_n;

  logic [N_SRC-1:0] rise;
  logic [N_SRC-1:0] grant_clr;
  logic [N_SRC-1:0] new_ovr;
  logic [N_SRC-1:0] pending_nxt;
  logic [N_SRC-1:0] overrun_nxt;
  logic [ID_W-1:0]  sel;
  logic             any;
  logic             grant;

  rr_pick #(
    .N_SRC (N_SRC)
  ) u_rr_pick (
    .pending (pending),
    .rr_ptr  (rr_ptr),
    .sel     (sel),
    .any     (any)
  );

  // A grant can only start from IDLE, which also enforces the turnaround gap
  assign grant = (state == ST_IDLE) && any;

  // Pending/overrun bookkeeping. A rise on the same edge as its own grant
  // re-arms the source instead of counting as an overrun.
  always_comb begin
    rise      = bus.req_i & ~req_q;
    grant_clr = '0;
    if (grant) begin
      grant_clr[sel] = 1'b1;
    end
    new_ovr     = rise & pending & ~grant_clr;
    pending_nxt = rise | (pending & ~grant_clr);
    overrun_nxt = new_ovr | (bus.ovr_clr_i ? '0 : overrun);
  end

  // Main FSM and all registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      req_q       <= '0;
      pending     <= '0;
      overrun     <= '0;
      rr_ptr      <= '0;
      hold_cnt    <= '0;
      winner_id   <= '0;
      ack_id_bus  <= '0;
      ack_event   <= 1'b0;
      ack_valid_n <= 1'b1;
    end else begin
      req_q     <= bus.req_i;
      pending   <= pending_nxt;
      overrun   <= overrun_nxt;
      ack_event <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (grant) begin
            state       <= ST_DRIVE;
            ack_valid_n <= 1'b0;
            ack_id_bus  <= sel;
            winner_id   <= sel;
            ack_event   <= 1'b1;
            rr_ptr      <= (int'(sel) == N_SRC - 1) ? '0 : sel + 1'b1;
            hold_cnt    <= 4'(HOLD_CYCLES - 1);
          end
        end
        ST_DRIVE: begin
          if (hold_cnt != 4'd0) begin
            hold_cnt <= hold_cnt - 4'd1;
          end else begin
            state       <= ST_IDLE;
            ack_valid_n <= 1'b1;
            ack_id_bus  <= '0;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.ack_ready_o       = ~pending;
  assign bus.winner_id_o       = winner_id;
  assign bus.ack_event_o       = ack_event;
  assign bus.ack_valid_n_bus_o = ack_valid_n;
  assign bus.ack_id_bus_o      = ack_id_bus;
  assign bus.overrun_o         = overrun;

endmodule
